// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the 4-lane adaptive traffic-light controller and
//   its front-end blocks (sensor conditioner, FSM, future lane-level logic).
//
//   Lane bit order used on every lane vector: [0]=NS, [1]=SN, [2]=EW, [3]=WE.
//
//   Contents:
//     LANE_NS/LANE_SN/LANE_EW/LANE_WE  lane index constants
//     NUM_LANES                        number of lanes
//     DEF_*                            default timing / counter widths
//     lane_vec_t                       one bit per lane
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam int NUM_LANES = 4;

    localparam int LANE_NS = 0;
    localparam int LANE_SN = 1;
    localparam int LANE_EW = 2;
    localparam int LANE_WE = 3;

    localparam int DEF_DB_CYCLES    = 4;
    localparam int DEF_CONG_CYCLES  = 16;
    localparam int DEF_STUCK_CYCLES = 1024;
    localparam int DEF_CNT_W        = 11;

    typedef logic [NUM_LANES-1:0] lane_vec_t;

endpackage

// File: rtl/lane_debounce.sv
// ---------------------------------------------------------------------------
// lane_debounce
//   Single-bit conditioner for one raw loop detector: a 2-flop synchroniser
//   followed by a sample_en-paced debounce counter.
//
//   The debounced value only flips after the synced input has disagreed with
//   it for DB_CYCLES sample_en pulses in a row; any cycle of agreement clears
//   the counter, so short glitches never reach db_out.
//
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous, active-high reset
//     sample_en  in   counter advance strobe (counter holds when low)
//     raw_in     in   raw asynchronous detector bit
//     sync_out   out  synchroniser stage-2 output
//     db_out     out  debounced value
// ---------------------------------------------------------------------------
module lane_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic raw_in,
    output logic sync_out,
    output logic db_out
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;

        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (sample_en) begin
            // This pulse is the DB_CYCLES-th disagreement: accept the new value.
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_out = sync2_q;
    assign db_out   = db_q;

endmodule

// File: rtl/lane_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// lane_sensor_conditioner
//   Front-end for the 4-lane adaptive traffic-light FSM. Synchronises and
//   debounces the raw loop detectors of every lane, then produces:
//     s1_req  - latched per-lane demand (sampled by the FSM in <lane>_RED)
//     s5_cong - persistence-qualified congestion (sampled in PRIMARY_GREEN)
//     fault   - stuck start-of-lane detector flag
//
//   Optional feature, macro STUCK_DETECT_EN:
//     defined   - a lane whose synced s1 stays high for STUCK_CYCLES sample_en
//                 pulses gets a sticky fault; while faulted, s1_req follows
//                 ~lane_served (fail-safe recall) and s5_cong is forced low.
//     undefined - no stuck counters, fault is tied to 0.
//
//   Ports (lane vectors are [0]=NS, [1]=SN, [2]=EW, [3]=WE):
//     clk          in   system clock
//     rst          in   asynchronous, active-high reset
//     sample_en    in   counter advance strobe; counters hold when low
//     s1_raw       in   raw start-of-lane detectors (asynchronous)
//     s5_raw       in   raw 5th-position queue detectors (asynchronous)
//     lane_served  in   high while the lane is green/yellow; clears demand
//     s1_req       out  latched demand
//     s5_cong      out  congestion flag
//     fault        out  stuck-detector flag
//
//   CNT_W must be wide enough to hold max(DB_CYCLES, CONG_CYCLES, STUCK_CYCLES).
// ---------------------------------------------------------------------------
module lane_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int CONG_CYCLES  = DEF_CONG_CYCLES,
    parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    input  logic [NUM_LANES-1:0] s1_raw,
    input  logic [NUM_LANES-1:0] s5_raw,
    input  logic [NUM_LANES-1:0] lane_served,
    output logic [NUM_LANES-1:0] s1_req,
    output logic [NUM_LANES-1:0] s5_cong,
    output logic [NUM_LANES-1:0] fault
);

    logic [NUM_LANES-1:0] s1_sync;
    logic [NUM_LANES-1:0] s1_db;
    logic [NUM_LANES-1:0] s5_sync;
    logic [NUM_LANES-1:0] s5_db;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane

        lane_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_s1_db (
            .clk       (clk),
            .rst       (rst),
            .sample_en (sample_en),
            .raw_in    (s1_raw[i]),
            .sync_out  (s1_sync[i]),
            .db_out    (s1_db[i])
        );

        lane_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_s5_db (
            .clk       (clk),
            .rst       (rst),
            .sample_en (sample_en),
            .raw_in    (s5_raw[i]),
            .sync_out  (s5_sync[i]),
            .db_out    (s5_db[i])
        );

        logic             req_q, req_d;
        logic [CNT_W-1:0] cong_cnt_q, cong_cnt_d;
        logic             cong_hit;

        // Serving the lane clears demand even if a vehicle is detected in the
        // same cycle; a vehicle still present re-raises demand once served drops.
        always_comb begin
            req_d = lane_served[i] ? 1'b0 : (req_q | s1_db[i]);
        end

        always_comb begin
            cong_cnt_d = cong_cnt_q;
            if (!s5_db[i]) begin
                cong_cnt_d = '0;
            end else if (sample_en && (cong_cnt_q != CNT_W'(CONG_CYCLES))) begin
                cong_cnt_d = cong_cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                req_q      <= 1'b0;
                cong_cnt_q <= '0;
            end else begin
                req_q      <= req_d;
                cong_cnt_q <= cong_cnt_d;
            end
        end

        // Both terms are registers. Qualifying with s5_db drops congestion in
        // the same cycle the debounced queue detector falls, one edge ahead of
        // the counter clearing.
        assign cong_hit = s5_db[i] & (cong_cnt_q == CNT_W'(CONG_CYCLES));

`ifdef STUCK_DETECT_EN
        logic [CNT_W-1:0] stuck_cnt_q, stuck_cnt_d;
        logic             fault_q, fault_d;

        always_comb begin
            stuck_cnt_d = stuck_cnt_q;
            if (!s1_sync[i]) begin
                stuck_cnt_d = '0;
            end else if (sample_en && (stuck_cnt_q != CNT_W'(STUCK_CYCLES))) begin
                stuck_cnt_d = stuck_cnt_q + CNT_W'(1);
            end
        end

        // Sticky until reset: a detector that once looked stuck is not trusted again.
        always_comb begin
            fault_d = fault_q | (stuck_cnt_d == CNT_W'(STUCK_CYCLES));
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stuck_cnt_q <= '0;
                fault_q     <= 1'b0;
            end else begin
                stuck_cnt_q <= stuck_cnt_d;
                fault_q     <= fault_d;
            end
        end

        assign s1_req[i]  = fault_q ? ~lane_served[i] : req_q;
        assign s5_cong[i] = ~fault_q & cong_hit;
        assign fault[i]   = fault_q;
`else
        assign s1_req[i]  = req_q;
        assign s5_cong[i] = cong_hit;
        assign fault[i]   = 1'b0;
`endif

    end

endmodule

// File: tb/tb_lane_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_lane_sensor_conditioner
//   Directed, self-checking bench for lane_sensor_conditioner.
//   Edge numbering: inputs change 1 time unit after a rising edge, called
//   edge 0; the following rising edges are edges 1, 2, ... Outputs are
//   sampled 1 time unit after each edge.
//   The DUT is built with STUCK_CYCLES=32 so the stuck-detector scenario is
//   short when STUCK_DETECT_EN is defined.
// ---------------------------------------------------------------------------
module tb_lane_sensor_conditioner;

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic [3:0] s1_raw;
    logic [3:0] s5_raw;
    logic [3:0] lane_served;
    logic [3:0] s1_req;
    logic [3:0] s5_cong;
    logic [3:0] fault;

    int vec_count;
    int err_count;

    lane_sensor_conditioner #(
        .DB_CYCLES    (4),
        .CONG_CYCLES  (16),
        .STUCK_CYCLES (32),
        .CNT_W        (11)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .s1_raw      (s1_raw),
        .s5_raw      (s5_raw),
        .lane_served (lane_served),
        .s1_req      (s1_req),
        .s5_cong     (s5_cong),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sample_en   = 1'b1;
        s1_raw      = 4'b0000;
        s5_raw      = 4'b0000;
        lane_served = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        sample_en   = 1'b1;
        s1_raw      = 4'b1111;
        s5_raw      = 4'b1111;
        lane_served = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
        end
        vec_count++;
        if (s1_req !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL reset_s1_req got %b want %b", s1_req, 4'b0000);
        end
        vec_count++;
        if (s5_cong !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL reset_s5_cong got %b want %b", s5_cong, 4'b0000);
        end
        vec_count++;
        if (fault !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL reset_fault got %b want %b", fault, 4'b0000);
        end
    endtask

    task automatic test_s1_latency();
        logic [3:0] exp;
        do_reset();
        s1_raw = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp = (k >= 7) ? 4'b0001 : 4'b0000;
            vec_count++;
            if (s1_req !== exp) begin
                err_count++;
                $display("[TB] FAIL s1_latency edge %0d got %b want %b", k, s1_req, exp);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        s1_raw = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            step();
        end
        s1_raw = 4'b0000;
        for (int k = 4; k <= 14; k++) begin
            step();
            vec_count++;
            if (s1_req !== 4'b0000) begin
                err_count++;
                $display("[TB] FAIL glitch3 edge %0d got %b want %b", k, s1_req, 4'b0000);
            end
        end
        // A 4-clock pulse is exactly long enough to be accepted and latched.
        do_reset();
        s1_raw = 4'b0100;
        for (int k = 1; k <= 4; k++) begin
            step();
        end
        s1_raw = 4'b0000;
        for (int k = 5; k <= 14; k++) begin
            step();
        end
        vec_count++;
        if (s1_req !== 4'b0100) begin
            err_count++;
            $display("[TB] FAIL pulse4_latched got %b want %b", s1_req, 4'b0100);
        end
    endtask

    task automatic test_demand_clear();
        do_reset();
        s1_raw = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
        end
        lane_served = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            step();
            vec_count++;
            if (s1_req !== 4'b0000) begin
                err_count++;
                $display("[TB] FAIL served_clear cycle %0d got %b want %b", k, s1_req, 4'b0000);
            end
        end
        lane_served = 4'b0000;
        step();
        vec_count++;
        if (s1_req !== 4'b0001) begin
            err_count++;
            $display("[TB] FAIL served_reassert got %b want %b", s1_req, 4'b0001);
        end
    endtask

    task automatic test_clear_wins();
        do_reset();
        s1_raw      = 4'b0001;
        lane_served = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
        end
        vec_count++;
        if (s1_req !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL clear_wins got %b want %b", s1_req, 4'b0000);
        end
        lane_served = 4'b0000;
        step();
        vec_count++;
        if (s1_req !== 4'b0001) begin
            err_count++;
            $display("[TB] FAIL clear_wins_release got %b want %b", s1_req, 4'b0001);
        end
    endtask

    task automatic test_multi_served();
        do_reset();
        s1_raw = 4'b0101;
        for (int k = 1; k <= 7; k++) begin
            step();
        end
        vec_count++;
        if (s1_req !== 4'b0101) begin
            err_count++;
            $display("[TB] FAIL multi_set got %b want %b", s1_req, 4'b0101);
        end
        lane_served = 4'b0101;
        step();
        vec_count++;
        if (s1_req !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL multi_clear got %b want %b", s1_req, 4'b0000);
        end
        lane_served = 4'b0100;
        step();
        vec_count++;
        if (s1_req !== 4'b0001) begin
            err_count++;
            $display("[TB] FAIL multi_partial got %b want %b", s1_req, 4'b0001);
        end
    endtask

    task automatic test_congestion();
        logic [3:0] exp;
        // lane_served held on lane 1 the whole time: it must not affect congestion.
        do_reset();
        lane_served = 4'b0010;
        s5_raw      = 4'b0010;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k >= 20 && k <= 23) begin
                exp = (k >= 22) ? 4'b0010 : 4'b0000;
                vec_count++;
                if (s5_cong !== exp) begin
                    err_count++;
                    $display("[TB] FAIL cong_rise edge %0d got %b want %b", k, s5_cong, exp);
                end
            end
        end
        s5_raw = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k >= 6) ? 4'b0000 : 4'b0010;
            vec_count++;
            if (s5_cong !== exp) begin
                err_count++;
                $display("[TB] FAIL cong_fall edge %0d got %b want %b", k, s5_cong, exp);
            end
        end
        // 15 pulses of debounced high: never asserts.
        do_reset();
        s5_raw = 4'b0010;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 15) s5_raw = 4'b0000;
            vec_count++;
            if (s5_cong !== 4'b0000) begin
                err_count++;
                $display("[TB] FAIL cong_15 edge %0d got %b want %b", k, s5_cong, 4'b0000);
            end
        end
        // 16 pulses with the debounced value still high at the 16th: one-cycle assert.
        do_reset();
        s5_raw = 4'b0010;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 17) s5_raw = 4'b0000;
            if (k >= 21) begin
                exp = (k == 22) ? 4'b0010 : 4'b0000;
                vec_count++;
                if (s5_cong !== exp) begin
                    err_count++;
                    $display("[TB] FAIL cong_16 edge %0d got %b want %b", k, s5_cong, exp);
                end
            end
        end
    endtask

    task automatic test_sparse_sample();
        logic [3:0] exp;
        do_reset();
        s1_raw = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            sample_en = ((k % 4) == 0);
            step();
            exp = (k >= 17) ? 4'b0001 : 4'b0000;
            vec_count++;
            if (s1_req !== exp) begin
                err_count++;
                $display("[TB] FAIL sparse edge %0d got %b want %b", k, s1_req, exp);
            end
        end
        sample_en = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        s1_raw = 4'b0001;
        s5_raw = 4'b0001;
        for (int k = 1; k <= 24; k++) begin
            step();
        end
        vec_count++;
        if ({s1_req, s5_cong} !== 8'b0001_0001) begin
            err_count++;
            $display("[TB] FAIL pre_reset got %b want %b", {s1_req, s5_cong}, 8'b0001_0001);
        end
        #2;
        rst = 1'b1;
        #1;
        vec_count++;
        if ({s1_req, s5_cong} !== 8'b0000_0000) begin
            err_count++;
            $display("[TB] FAIL async_reset got %b want %b", {s1_req, s5_cong}, 8'b0000_0000);
        end
        s1_raw = 4'b0000;
        s5_raw = 4'b0000;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
        end
        vec_count++;
        if ({s1_req, s5_cong} !== 8'b0000_0000) begin
            err_count++;
            $display("[TB] FAIL post_reset got %b want %b", {s1_req, s5_cong}, 8'b0000_0000);
        end
    endtask

`ifdef STUCK_DETECT_EN
    task automatic test_stuck();
        logic [3:0] exp;
        do_reset();
        s1_raw = 4'b1000;
        for (int k = 1; k <= 36; k++) begin
            step();
            if (k >= 32) begin
                exp = (k >= 34) ? 4'b1000 : 4'b0000;
                vec_count++;
                if (fault !== exp) begin
                    err_count++;
                    $display("[TB] FAIL stuck_fault edge %0d got %b want %b", k, fault, exp);
                end
            end
        end
        lane_served = 4'b1000;
        #1;
        vec_count++;
        if (s1_req !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL stuck_served got %b want %b", s1_req, 4'b0000);
        end
        lane_served = 4'b0000;
        #1;
        vec_count++;
        if (s1_req !== 4'b1000) begin
            err_count++;
            $display("[TB] FAIL stuck_recall got %b want %b", s1_req, 4'b1000);
        end
        s5_raw = 4'b1000;
        for (int k = 1; k <= 30; k++) begin
            step();
        end
        vec_count++;
        if (s5_cong !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL stuck_cong got %b want %b", s5_cong, 4'b0000);
        end
        do_reset();
        vec_count++;
        if (fault !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL stuck_rst got %b want %b", fault, 4'b0000);
        end
    endtask
`else
    task automatic test_stuck();
        do_reset();
        s1_raw = 4'b1000;
        for (int k = 1; k <= 40; k++) begin
            step();
        end
        vec_count++;
        if (fault !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL nostuck_fault got %b want %b", fault, 4'b0000);
        end
        lane_served = 4'b1000;
        step();
        vec_count++;
        if (s1_req !== 4'b0000) begin
            err_count++;
            $display("[TB] FAIL nostuck_served got %b want %b", s1_req, 4'b0000);
        end
    endtask
`endif

    initial begin
        vec_count   = 0;
        err_count   = 0;
        rst         = 1'b1;
        sample_en   = 1'b0;
        s1_raw      = 4'b0000;
        s5_raw      = 4'b0000;
        lane_served = 4'b0000;

        test_reset();
        test_s1_latency();
        test_glitch();
        test_demand_clear();
        test_clear_wins();
        test_multi_served();
        test_congestion();
        test_sparse_sample();
        test_async_reset();
        test_stuck();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
